// File: rtl/lvt_ram_mrmw.sv
// Multi-read/multi-write RAM using a live-value table: one bank per write port, LVT picks the live bank.
// Optional macro LVT_RAM_BYPASS_EN makes same-edge read-during-write return the incoming data.
module lvt_ram_mrmw #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int NW     = 4,
    parameter int NR     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NW-1:0]        w_enb,
    input  logic [NW*ADDR_W-1:0] w_addr,
    input  logic [NW*DATA_W-1:0] w_din,
    input  logic [NR-1:0]        r_enb,
    input  logic [NR*ADDR_W-1:0] r_addr,
    output logic [NR*DATA_W-1:0] r_dout,
    output logic [NR-1:0]        r_valid,
    output logic                 init_busy,
    output logic                 wr_conflict
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LVT_W = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     cnt_q, cnt_d;
    logic                  init_busy_q, init_busy_d;
    logic [NR*DATA_W-1:0]  r_dout_q, r_dout_d;
    logic [NR-1:0]         r_valid_q, r_valid_d;
    logic                  wr_conflict_q, wr_conflict_d;

    logic                  run;
    logic [NW-1:0]         w_act;
    logic [LVT_W-1:0]      lvt_mem [DEPTH];
    logic [LVT_W-1:0]      lvt_rd  [NR];
    logic [DATA_W-1:0]     bank_rd [NW][NR];
    logic [DATA_W-1:0]     rd_sel  [NR];

    assign run   = (state_q == ST_RUN);
    assign w_act = run ? w_enb : '0;

    // Later ports overwrite earlier ones, so the highest-index writer owns the entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                lvt_mem[cnt_q] <= '0;
            end
            for (int p = 0; p < NW; p++) begin
                if (w_act[p]) begin
                    lvt_mem[w_addr[p*ADDR_W +: ADDR_W]] <= LVT_W'(p);
                end
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < NR; gi++) begin : g_lvt_rd
            assign lvt_rd[gi] = lvt_mem[r_addr[gi*ADDR_W +: ADDR_W]];
        end

        for (gi = 0; gi < NW; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [DEPTH];
            logic              we;
            logic [ADDR_W-1:0] wa;
            logic [DATA_W-1:0] wd;

            // Only bank 0 is swept; the others stay unselected until written.
            always_comb begin
                we = w_act[gi];
                wa = w_addr[gi*ADDR_W +: ADDR_W];
                wd = w_din[gi*DATA_W +: DATA_W];
                if (gi == 0 && state_q == ST_INIT) begin
                    we = 1'b1;
                    wa = cnt_q;
                    wd = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst && we) begin
                    mem[wa] <= wd;
                end
            end

            for (gj = 0; gj < NR; gj++) begin : g_rd
                assign bank_rd[gi][gj] = mem[r_addr[gj*ADDR_W +: ADDR_W]];
            end
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rd_sel[i] = bank_rd[lvt_rd[i]][i];
`ifdef LVT_RAM_BYPASS_EN
            for (int p = 0; p < NW; p++) begin
                if (w_act[p] && (w_addr[p*ADDR_W +: ADDR_W] == r_addr[i*ADDR_W +: ADDR_W])) begin
                    rd_sel[i] = w_din[p*DATA_W +: DATA_W];
                end
            end
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        init_busy_d   = init_busy_q;
        r_dout_d      = r_dout_q;
        r_valid_d     = '0;
        wr_conflict_d = 1'b0;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {ADDR_W{1'b1}}) begin
                state_d     = ST_RUN;
                init_busy_d = 1'b0;
            end
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (r_enb[i]) begin
                    r_dout_d[i*DATA_W +: DATA_W] = rd_sel[i];
                    r_valid_d[i]                 = 1'b1;
                end
            end
            for (int p = 0; p < NW; p++) begin
                for (int q = p + 1; q < NW; q++) begin
                    if (w_enb[p] && w_enb[q] &&
                        (w_addr[p*ADDR_W +: ADDR_W] == w_addr[q*ADDR_W +: ADDR_W])) begin
                        wr_conflict_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            init_busy_q   <= 1'b1;
            r_dout_q      <= '0;
            r_valid_q     <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            init_busy_q   <= init_busy_d;
            r_dout_q      <= r_dout_d;
            r_valid_q     <= r_valid_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign r_dout      = r_dout_q;
    assign r_valid     = r_valid_q;
    assign init_busy   = init_busy_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_lvt_ram_mrmw.sv
// Self-checking bench for lvt_ram_mrmw: directed vector table, init/reset sequences, random traffic vs flat-memory model.
module tb_lvt_ram_mrmw;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int NW     = 4;
    localparam int NR     = 4;

`ifdef LVT_RAM_BYPASS_EN
    localparam logic [31:0] RDW5 = 32'h99;
    localparam logic [31:0] RDW6 = 32'h62;
`else
    localparam logic [31:0] RDW5 = 32'h10;
    localparam logic [31:0] RDW6 = 32'h0;
`endif

    logic                 clk;
    logic                 rst;
    logic [NW-1:0]        w_enb;
    logic [NW*ADDR_W-1:0] w_addr;
    logic [NW*DATA_W-1:0] w_din;
    logic [NR-1:0]        r_enb;
    logic [NR*ADDR_W-1:0] r_addr;
    logic [NR*DATA_W-1:0] r_dout;
    logic [NR-1:0]        r_valid;
    logic                 init_busy;
    logic                 wr_conflict;

    lvt_ram_mrmw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NW(NW), .NR(NR)) dut (
        .clk(clk), .rst(rst),
        .w_enb(w_enb), .w_addr(w_addr), .w_din(w_din),
        .r_enb(r_enb), .r_addr(r_addr),
        .r_dout(r_dout), .r_valid(r_valid),
        .init_busy(init_busy), .wr_conflict(wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one flat word per address plus expected output registers.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_dout [NR];
    logic        m_valid [NR];
    logic        m_conf;
    logic        m_busy;
    int          m_left;

    typedef struct {
        logic [3:0]   we;
        logic [15:0]  wa;
        logic [127:0] wd;
        logic [3:0]   re;
        logic [15:0]  ra;
        logic         exp_conf;
        logic [3:0]   exp_valid;
        logic [127:0] exp_dout;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(logic [3:0] we, logic [15:0] wa, logic [127:0] wd,
                                logic [3:0] re, logic [15:0] ra,
                                logic ec, logic [3:0] ev, logic [127:0] ed);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.exp_conf = ec; v.exp_valid = ev; v.exp_dout = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Predict the effect of the coming edge, take the edge, then compare everything.
    task automatic cycle();
        logic [31:0] d;
        if (rst) begin
            m_busy = 1'b1;
            m_left = DEPTH;
            m_conf = 1'b0;
            for (int i = 0; i < NR; i++) begin m_valid[i] = 1'b0; m_dout[i] = '0; end
            for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
            m_conf = 1'b0;
            for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
        end else begin
            m_conf = 1'b0;
            for (int p = 0; p < NW; p++)
                for (int q = p + 1; q < NW; q++)
                    if (w_enb[p] && w_enb[q] && w_addr[p*4 +: 4] == w_addr[q*4 +: 4]) m_conf = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (r_enb[i]) begin
                    d = m_mem[r_addr[i*4 +: 4]];
`ifdef LVT_RAM_BYPASS_EN
                    for (int p = 0; p < NW; p++)
                        if (w_enb[p] && w_addr[p*4 +: 4] == r_addr[i*4 +: 4]) d = w_din[p*32 +: 32];
`endif
                    m_dout[i]  = d;
                    m_valid[i] = 1'b1;
                end else begin
                    m_valid[i] = 1'b0;
                end
            end
            for (int p = 0; p < NW; p++)
                if (w_enb[p]) m_mem[w_addr[p*4 +: 4]] = w_din[p*32 +: 32];
        end
        @(posedge clk);
        #1;
        chk("init_busy", {31'd0, init_busy}, {31'd0, m_busy});
        chk("wr_conflict", {31'd0, wr_conflict}, {31'd0, m_conf});
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("r_valid%0d", i), {31'd0, r_valid[i]}, {31'd0, m_valid[i]});
            chk($sformatf("r_dout%0d", i), r_dout[i*32 +: 32], m_dout[i]);
        end
        $display("t=%0t rst=%b we=%h wa=%h re=%h ra=%h busy=%b conf=%b rv=%h dout=%h",
                 $time, rst, w_enb, w_addr, r_enb, r_addr, init_busy, wr_conflict, r_valid, r_dout);
    endtask

    // Runs edges until init_busy drops, optionally hammering requests meanwhile.
    task automatic count_init(input logic [3:0] req);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < 64) begin
            w_enb  = req;
            r_enb  = req;
            w_addr = 16'($urandom);
            r_addr = 16'($urandom);
            w_din  = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            n++;
        end
        w_enb = '0;
        r_enb = '0;
        chk("init_len", n, 32'd16);
    endtask

    task automatic read_all_zero();
        cycle();
        for (int b = 0; b < DEPTH; b += 4) begin
            r_enb  = 4'hF;
            r_addr = {4'(b + 3), 4'(b + 2), 4'(b + 1), 4'(b)};
            cycle();
            for (int i = 0; i < NR; i++)
                chk($sformatf("zero_a%0d", b + i), r_dout[i*32 +: 32], 32'd0);
        end
        r_enb = '0;
        cycle();
    endtask

    initial begin
        rst = 1'b1; w_enb = '0; w_addr = '0; w_din = '0; r_enb = '0; r_addr = '0;

        // Reset for two cycles, then a clean init sweep.
        cycle();
        cycle();
        rst = 1'b0;
        count_init(4'h0);
        read_all_zero();

        // Directed vectors; contents are all zero on entry.
        vecs[0]  = mk(4'hF, {4'd4, 4'd3, 4'd2, 4'd1}, {32'hD3, 32'hC2, 32'hB1, 32'hA0},
                      4'h0, 16'h0, 1'b0, 4'h0, 128'h0);
        vecs[1]  = mk(4'h0, 16'h0, 128'h0, 4'hF, {4'd4, 4'd3, 4'd2, 4'd1},
                      1'b0, 4'hF, {32'hD3, 32'hC2, 32'hB1, 32'hA0});
        vecs[2]  = mk(4'b1011, {4'd7, 4'd7, 4'd7, 4'd7}, {32'h44, 32'h33, 32'h22, 32'h11},
                      4'h0, 16'h0, 1'b1, 4'h0, 128'h0);
        vecs[3]  = mk(4'h0, 16'h0, 128'h0, 4'h1, 16'h0007, 1'b0, 4'h1, {96'h0, 32'h44});
        vecs[4]  = mk(4'h1, 16'h0007, {96'h0, 32'h55}, 4'h0, 16'h0, 1'b0, 4'h0, 128'h0);
        vecs[5]  = mk(4'h0, 16'h0, 128'h0, 4'hF, 16'h7777, 1'b0, 4'hF,
                      {32'h55, 32'h55, 32'h55, 32'h55});
        vecs[6]  = mk(4'h1, 16'h0005, {96'h0, 32'h10}, 4'h0, 16'h0, 1'b0, 4'h0, 128'h0);
        vecs[7]  = mk(4'h4, 16'h0500, {32'h0, 32'h99, 64'h0}, 4'h1, 16'h0005,
                      1'b0, 4'h1, {96'h0, RDW5});
        vecs[8]  = mk(4'h0, 16'h0, 128'h0, 4'h1, 16'h0005, 1'b0, 4'h1, {96'h0, 32'h99});
        vecs[9]  = mk(4'h6, 16'h0660, {32'h0, 32'h62, 32'h61, 32'h0}, 4'h8, 16'h6000,
                      1'b1, 4'h8, {RDW6, 96'h0});
        vecs[10] = mk(4'h0, 16'h0, 128'h0, 4'h2, 16'h0060, 1'b0, 4'h2, {64'h0, 32'h62, 32'h0});

        for (int k = 0; k < 11; k++) begin
            w_enb = vecs[k].we; w_addr = vecs[k].wa; w_din = vecs[k].wd;
            r_enb = vecs[k].re; r_addr = vecs[k].ra;
            cycle();
            chk($sformatf("vec%0d_conf", k), {31'd0, wr_conflict}, {31'd0, vecs[k].exp_conf});
            chk($sformatf("vec%0d_valid", k), {28'd0, r_valid}, {28'd0, vecs[k].exp_valid});
            for (int i = 0; i < NR; i++)
                if (vecs[k].exp_valid[i])
                    chk($sformatf("vec%0d_dout%0d", k, i), r_dout[i*32 +: 32], vecs[k].exp_dout[i*32 +: 32]);
        end

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            w_enb  = 4'($urandom);
            w_addr = 16'($urandom);
            w_din  = {$urandom, $urandom, $urandom, $urandom};
            r_enb  = 4'($urandom);
            r_addr = 16'($urandom);
            cycle();
        end
        w_enb = '0;
        r_enb = '0;

        // Reset after RUN activity, with requests ignored during the sweep.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        count_init(4'hF);
        read_all_zero();

        // Reset again in the middle of a sweep (counter at 9).
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (9) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        count_init(4'hF);
        read_all_zero();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lvt_ram_mrmw.md
Name: lvt_ram_mrmw

Overview:
Parametrised multi-read/multi-write RAM built on the live-value-table (LVT) method: one storage bank per write port, each bank readable by every read port, and an LVT that records which bank holds the latest value of each address. Single-edge, fully synchronous successor to the fixed 4R4W block. Adds:
- generic port counts and widths
- registered reads with valid flags
- defined same-address write priority
- a post-reset initialisation sweep

It sits as the register-file / shared-scratchpad primitive for multi-issue datapaths.

Parameters:
DATA_W, 32, data word width.
ADDR_W, 11, address width; DEPTH = 2**ADDR_W.
NW, 4, write ports / banks, 1..8.
NR, 4, read ports, 1..8.
LVT_W, derived localparam = max(1, clog2(NW)), LVT entry width; not overridable.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  reset, synchronous, active-high.
w_enb  in  NW  per-port write enable.
w_addr  in  NW*ADDR_W  write addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
w_din  in  NW*DATA_W  write data; port p occupies [p*DATA_W +: DATA_W].
r_enb  in  NR  per-port read enable.
r_addr  in  NR*ADDR_W  read addresses, packed as w_addr.
r_dout  out  NR*DATA_W  registered read data.
r_valid  out  NR  r_dout slice valid this cycle.
init_busy  out  1  initialisation sweep in progress; all requests ignored.
wr_conflict  out  1  one-cycle pulse: two or more enabled writes hit the same address.

Behaviour:
- Reset: at a posedge with rst=1, the following load:
  - state<=INIT, init counter<=0, init_busy<=1
  - r_dout<=0, r_valid<=0, wr_conflict<=0
  - Reset outranks all other activity.
- INIT state: each posedge with rst=0 writes 0 to bank 0 [cnt] and 0 to lvt[cnt], then cnt++.
  - At cnt==DEPTH-1: state<=RUN, init_busy<=0.
  - init_busy therefore falls exactly DEPTH posedges after the first non-reset edge.
  - rst reasserted mid-sweep restarts it at address 0.
  - During INIT: w_enb and r_enb are ignored; r_valid stays 0.
- Post-init contents: every address reads 0, because the LVT points to bank 0. Banks 1..NW-1 are never cleared and must never be selected before being written.
- RUN write: at posedge, each port p with w_enb[p]=1 writes bank p[w_addr_p]<=w_din_p and lvt[w_addr_p]<=p.
  - Same address on several enabled ports: the highest-index port wins the LVT entry; the other banks still write but become stale.
  - wr_conflict<=1 on the next edge, for one cycle per conflicting cycle.
- RUN read: at posedge, each port i with r_enb[i]=1 loads r_dout_i<=bank[lvt[r_addr_i]][r_addr_i] and r_valid[i]<=1.
  - Latency is 1 cycle.
  - r_enb[i]=0: r_valid[i]<=0 and r_dout_i holds its previous value.
  - Reads are independent; any number of ports may read the same address.
- Read-during-write, same address, same edge: returns the old value (read-first), since LVT and banks are sampled before update.
- Next-cycle read after a write returns the new value.
- The LVT is a register array (NR+NW ports). Banks are behavioural arrays with NR read ports and 1 write port each.
- No X may reach r_dout after INIT for any address.

Optional Feature:
Macro LVT_RAM_BYPASS_EN.
- Defined: same-edge read-during-write to the same address returns the incoming data of the highest-index enabled writer to that address (write-first). wr_conflict is unchanged.
- Undefined: read-first, as above; no bypass muxes are built.

Test Plan:
(Bench uses ADDR_W=4, DEPTH=16, NW=NR=4, DATA_W=32.)
1. Reset and init:
   - Stimulus: rst=1 for 2 cycles, then 0.
   - Response: init_busy=1 for exactly 16 edges, then 0. Reads of all 16 addresses give 0 with r_valid=1 one cycle after r_enb.
2. Parallel writes:
   - Stimulus: ports 0..3 write 0xA0,0xB1,0xC2,0xD3 to addresses 1,2,3,4 in one cycle.
   - Response: the next cycle, reads of 1,2,3,4 on ports 0..3 return the same values one cycle later; wr_conflict=0.
3. Collision:
   - Stimulus: ports 0,1,3 write 0x11,0x22,0x44 to address 7.
   - Response: wr_conflict=1 for one cycle. A read of 7 returns 0x44. A subsequent port 0 write of 0x55 to 7 makes reads return 0x55.
4. Read-during-write:
   - Stimulus: address 5 holds 0x10; port 2 writes 0x99 to 5 while read port 0 reads 5.
   - Response: 0x10 without the macro, 0x99 with LVT_RAM_BYPASS_EN. The next read returns 0x99 in both builds.
5. Reset mid-operation:
   - Stimulus: assert rst at init cnt=9, and again after writes in RUN.
   - Response: init restarts, taking a full 16 edges. Afterwards all addresses read 0, r_valid=0 until r_enb.
6. Requests during INIT:
   - Stimulus: w_enb=4'hF and r_enb=4'hF while init_busy=1.
   - Response: no r_valid, no wr_conflict. Contents after init are all 0.
